decode_pipe: RTL and testbench
==============================

Name: decode_pipe

Overview:
- Parametrised RV32I/M decode stage between fetch and execute.
- Registered with valid/ready handshakes on both sides and a one-entry skid buffer, so it sustains one instruction per cycle under back-pressure.
- Adds full sign-extended immediate generation, illegal-instruction detection, register-use flags, PC passthrough, flush, and a saturating illegal-instruction counter.

Parameters:
XLEN, 32, datapath width; immediates are sign-extended to XLEN (legal values 32 or 64).
PC_W, 32, width of the PC carried alongside the instruction.
ENABLE_M, 1, when 1, R-type with funct7=7'h01 is legal (M extension); when 0 it is illegal.
CNT_W, 16, width of the illegal-instruction counter.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held instructions
in_valid  input  1  fetch presents instruction
in_ready  output  1  stage can accept
in_instr  input  32  raw instruction
in_pc  input  PC_W  instruction PC
out_valid  output  1  decoded bundle valid
out_ready  input  1  execute accepts bundle
out_pc  output  PC_W  PC of decoded instruction
out_type  output  6  one-hot {r,i,s,b,u,j}, bit5=r ... bit0=j; 0 when illegal
out_opcode  output  7  instr[6:0]
out_rd  output  5  instr[11:7]
out_rs1  output  5  instr[19:15]
out_rs2  output  5  instr[24:20]
out_funct3  output  3  instr[14:12]
out_funct7  output  7  instr[31:25]
out_imm  output  XLEN  sign-extended immediate
out_alu_op  output  4  ALU operation code
out_rd_we  output  1  writes rd (0 if rd==0 or illegal)
out_use_rs1  output  1  reads rs1
out_use_rs2  output  1  reads rs2
out_illegal  output  1  instruction is illegal
illegal_count  output  CNT_W  saturating count of illegal instructions delivered

Behaviour:
- Reset (rst_n=0, async): out_valid=0, skid empty, in_ready=1, illegal_count=0, all output data fields 0.
- Latency: one cycle from the in_valid&&in_ready edge to out_valid.
- Transfer rules: a transfer occurs on in_valid&&in_ready or out_valid&&out_ready.
  - Output register empty, or draining this cycle: the new decode loads the output register.
  - Output register held with out_ready=0: the new decode goes to the skid buffer.
  - in_ready = ~skid_full, registered.
  - While the skid is full, an output transfer moves the skid into the output register and clears the skid.
- Ordering: strictly in order. Output data holds stable while out_valid=1 and out_ready=0.
- Flush:
  - Clears out_valid and the skid on the next edge; in_ready=1 after.
  - An input accepted in the flush cycle is dropped.
  - Flush has priority over all transfers.
- Type decode by opcode:
  - 33 -> r
  - 13, 03, 67 -> i
  - 23 -> s
  - 63 -> b
  - 37, 17 -> u
  - 6F -> j
- Illegal conditions:
  - any other opcode
  - instr[1:0] != 2'b11
  - R-type funct7 not in {00, 20, plus 01 when ENABLE_M}
  - opcode 13 with funct3=001 and funct7!=00
  - opcode 13 with funct3=101 and funct7 not in {00, 20}
- Illegal bundles still flow downstream with out_illegal=1, type=0, rd_we=0, use flags 0, imm=0.
- Immediates (sext = sign extension to XLEN):
  - I: sext(i[31:20])
  - S: sext({i[31:25],i[11:7]})
  - B: sext({i[31],i[7],i[30:25],i[11:8],1'b0})
  - U: sext({i[31:12],12'b0})
  - J: sext({i[31],i[19:12],i[20],i[30:21],1'b0})
  - R: 0
- ALU op:
  - R: {funct3, funct7[5]}; with funct7=01, {funct3,1'b1} is undefined here and is passed as-is with alu_op=4'b1111 marker (M unit decodes funct3).
  - OP-IMM: {funct3, funct3==101 ? funct7[5] : 0}.
  - Load, store, JALR, AUIPC, JAL: 4'b0000 (add).
  - Branch: 4'b0001 (sub).
  - LUI: 4'b1110 (pass imm).
- Register use:
  - use_rs1 = r|i|s|b.
  - use_rs2 = r|s|b.
  - rd_we = (r|i|u|j) && rd!=0 && !illegal.
- Counter: increments on each output transfer with out_illegal=1; saturates at all-ones; not cleared by flush.
- Simultaneous in and out transfer with the skid empty: the output register reloads and out_valid stays 1.

Test Plan:
1. Reset, then in 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, type=010000, imm=5, alu_op=0000, rd=1, rd_we=1.
2. in 0xFE000EE3 (beq x0,x0,-4) -> type=000100, imm=0xFFFFFFFC, alu_op=0001, use_rs2=1, rd_we=0.
3. Back-pressure: hold out_ready=0 while streaming 3 instrs -> first held stable, second in skid, in_ready=0 the cycle after; release -> all 3 delivered in order, no gaps.
4. in 0x0000007F, then 0x02208033 with ENABLE_M=0 -> both out_illegal=1, type=0; illegal_count=2.
5. Flush with output and skid both full and in_valid=1 -> next cycle out_valid=0, in_ready=1, none of the three appear.
6. XLEN=64, in 0x800000B7 (lui x1,0x80000) -> imm=0xFFFFFFFF80000000, alu_op=1110; assert rst_n=0 mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/decode_pipe.sv
// RV32I/M decode stage: registered output with a one-entry skid buffer, full
// immediate generation, illegal detection and a saturating illegal counter.
module decode_pipe #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PC_W     = 32,
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [5:0]       out_type,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_alu_op,
  output logic             out_rd_we,
  output logic             out_use_rs1,
  output logic             out_use_rs2,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [5:0]      typ;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic            rd_we;
    logic            use_rs1;
    logic            use_rs2;
    logic            illegal;
  } bundle_t;

  bundle_t          dec;
  bundle_t          out_q, out_d, skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] illegal_count_q, illegal_count_d;

  logic        is_r, is_i, is_s, is_b, is_u, is_j, ill;
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [31:0] imm32;
  logic [3:0]  alu;
  logic        in_fire, out_fire;

  always_comb begin
    op   = in_instr[6:0];
    f3   = in_instr[14:12];
    f7   = in_instr[31:25];
    is_r = 1'b0;
    is_i = 1'b0;
    is_s = 1'b0;
    is_b = 1'b0;
    is_u = 1'b0;
    is_j = 1'b0;
    case (op)
      7'h33:               is_r = 1'b1;
      7'h13, 7'h03, 7'h67: is_i = 1'b1;
      7'h23:               is_s = 1'b1;
      7'h63:               is_b = 1'b1;
      7'h37, 7'h17:        is_u = 1'b1;
      7'h6F:               is_j = 1'b1;
      default: ;
    endcase

    ill = !(is_r || is_i || is_s || is_b || is_u || is_j) || (in_instr[1:0] != 2'b11);
    if (is_r && !(f7 == 7'h00 || f7 == 7'h20 || (ENABLE_M && f7 == 7'h01))) ill = 1'b1;
    if (op == 7'h13 && f3 == 3'b001 && f7 != 7'h00) ill = 1'b1;
    if (op == 7'h13 && f3 == 3'b101 && !(f7 == 7'h00 || f7 == 7'h20)) ill = 1'b1;

    imm32 = '0;
    if (is_i)      imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
    else if (is_s) imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    else if (is_b) imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    else if (is_u) imm32 = {in_instr[31:12], 12'b0};
    else if (is_j) imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    alu = 4'b0000;
    if (is_r)              alu = (f7 == 7'h01) ? 4'b1111 : {f3, f7[5]};
    else if (op == 7'h13)  alu = {f3, (f3 == 3'b101) ? f7[5] : 1'b0};
    else if (is_b)         alu = 4'b0001;
    else if (op == 7'h37)  alu = 4'b1110;

    dec         = '0;
    dec.pc      = in_pc;
    dec.opcode  = op;
    dec.rd      = in_instr[11:7];
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.illegal = ill;
    if (!ill) begin
      dec.typ      = {is_r, is_i, is_s, is_b, is_u, is_j};
      dec.imm      = {XLEN{imm32[31]}};
      dec.imm[31:0] = imm32;
      dec.alu_op   = alu;
      dec.rd_we    = (is_r || is_i || is_u || is_j) && (in_instr[11:7] != 5'd0);
      dec.use_rs1  = is_r || is_i || is_s || is_b;
      dec.use_rs2  = is_r || is_s || is_b;
    end
  end

  assign in_ready = !skid_valid_q;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Flush wins over every transfer, including the illegal count of a bundle
  // draining in the same cycle. A full skid implies a held output register.
  always_comb begin
    out_d           = out_q;
    out_valid_d     = out_valid_q;
    skid_d          = skid_q;
    skid_valid_d    = skid_valid_q;
    illegal_count_d = illegal_count_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (out_fire && out_q.illegal && illegal_count_q != '1)
        illegal_count_d = illegal_count_q + CNT_W'(1);
      if (skid_valid_q) begin
        if (out_ready) begin
          out_d        = skid_q;
          skid_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        if (!out_valid_q || out_ready) begin
          out_d       = dec;
          out_valid_d = 1'b1;
        end else begin
          skid_d       = dec;
          skid_valid_d = 1'b1;
        end
      end else if (out_fire) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q           <= '0;
      out_valid_q     <= 1'b0;
      skid_q          <= '0;
      skid_valid_q    <= 1'b0;
      illegal_count_q <= '0;
    end else begin
      out_q           <= out_d;
      out_valid_q     <= out_valid_d;
      skid_q          <= skid_d;
      skid_valid_q    <= skid_valid_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = out_q.pc;
  assign out_type      = out_q.typ;
  assign out_opcode    = out_q.opcode;
  assign out_rd        = out_q.rd;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_funct3    = out_q.funct3;
  assign out_funct7    = out_q.funct7;
  assign out_imm       = out_q.imm;
  assign out_alu_op    = out_q.alu_op;
  assign out_rd_we     = out_q.rd_we;
  assign out_use_rs1   = out_q.use_rs1;
  assign out_use_rs2   = out_q.use_rs2;
  assign out_illegal   = out_q.illegal;
  assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: instance a is 32-bit without M, instance b
// is 64-bit with M and a 2-bit counter so saturation is reachable.
module tb_decode_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  typ;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [3:0]  alu;
    logic        rd_we;
    logic        u1;
    logic        u2;
    logic        ill;
  } exp_t;

  localparam logic [5:0] T_R = 6'b100000, T_I = 6'b010000, T_S = 6'b001000;
  localparam logic [5:0] T_B = 6'b000100, T_U = 6'b000010, T_J = 6'b000001, T_0 = 6'b000000;

  logic clk, rst_n;
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_instr, a_in_pc, a_out_pc, a_out_imm;
  logic [5:0]  a_out_type;
  logic [6:0]  a_out_opcode, a_out_funct7;
  logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
  logic [2:0]  a_out_funct3;
  logic [3:0]  a_out_alu_op;
  logic        a_out_rd_we, a_out_use_rs1, a_out_use_rs2, a_out_illegal;
  logic [15:0] a_illegal_count;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_instr, b_in_pc, b_out_pc;
  logic [63:0] b_out_imm;
  logic [5:0]  b_out_type;
  logic [6:0]  b_out_opcode, b_out_funct7;
  logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
  logic [2:0]  b_out_funct3;
  logic [3:0]  b_out_alu_op;
  logic        b_out_rd_we, b_out_use_rs1, b_out_use_rs2, b_out_illegal;
  logic [1:0]  b_illegal_count;

  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  decode_pipe #(.XLEN(32), .PC_W(32), .ENABLE_M(1'b0), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc), .out_type(a_out_type),
    .out_opcode(a_out_opcode), .out_rd(a_out_rd), .out_rs1(a_out_rs1), .out_rs2(a_out_rs2),
    .out_funct3(a_out_funct3), .out_funct7(a_out_funct7), .out_imm(a_out_imm),
    .out_alu_op(a_out_alu_op), .out_rd_we(a_out_rd_we), .out_use_rs1(a_out_use_rs1),
    .out_use_rs2(a_out_use_rs2), .out_illegal(a_out_illegal), .illegal_count(a_illegal_count)
  );

  decode_pipe #(.XLEN(64), .PC_W(32), .ENABLE_M(1'b1), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc), .out_type(b_out_type),
    .out_opcode(b_out_opcode), .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
    .out_funct3(b_out_funct3), .out_funct7(b_out_funct7), .out_imm(b_out_imm),
    .out_alu_op(b_out_alu_op), .out_rd_we(b_out_rd_we), .out_use_rs1(b_out_use_rs1),
    .out_use_rs2(b_out_use_rs2), .out_illegal(b_out_illegal), .illegal_count(b_illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic cmp_bundle(input string name, input exp_t act, input exp_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s pc=%h got=%h want=%h", name, e.pc, act, e);
    end
  endtask

  // Monitors: pop and compare on every output transfer.
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      exp_t act;
      act = '{a_out_pc, a_out_type, a_out_opcode, a_out_rd, a_out_rs1, a_out_rs2,
              a_out_funct3, a_out_funct7, {32'h0, a_out_imm}, a_out_alu_op,
              a_out_rd_we, a_out_use_rs1, a_out_use_rs2, a_out_illegal};
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_a got pc=%h want no output", a_out_pc);
      end else cmp_bundle("bundle_a", act, qa.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      exp_t act;
      act = '{b_out_pc, b_out_type, b_out_opcode, b_out_rd, b_out_rs1, b_out_rs2,
              b_out_funct3, b_out_funct7, b_out_imm, b_out_alu_op,
              b_out_rd_we, b_out_use_rs1, b_out_use_rs2, b_out_illegal};
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_b got pc=%h want no output", b_out_pc);
      end else cmp_bundle("bundle_b", act, qb.pop_front());
    end
  end

  task automatic send(input int sel, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [5:0] typ, input logic [63:0] imm, input logic [3:0] alu,
                      input logic rd_we, input logic u1, input logic u2, input logic ill);
    exp_t e;
    bit   acc;
    int   n;
    e = '{pc, typ, ins[6:0], ins[11:7], ins[19:15], ins[24:20], ins[14:12], ins[31:25],
          imm, alu, rd_we, u1, u2, ill};
    acc = 1'b0;
    n   = 0;
    if (sel == 0) begin a_in_valid = 1'b1; a_in_instr = ins; a_in_pc = pc; end
    else          begin b_in_valid = 1'b1; b_in_instr = ins; b_in_pc = pc; end
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = (sel == 0) ? a_in_ready : b_in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    if (sel == 0) a_in_valid = 1'b0; else b_in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout pc=%h got not accepted want accepted", pc);
    end else if (sel == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_instr = '0; a_in_pc = '0; a_out_ready = 1'b1;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_instr = '0; b_in_pc = '0; b_out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {63'h0, a_out_valid}, 64'h0);
    chk("rst_in_ready", {63'h0, a_in_ready}, 64'h1);
    chk("rst_count", {48'h0, a_illegal_count}, 64'h0);
    chk("rst_pc", {32'h0, a_out_pc}, 64'h0);
    chk("rst_imm_b", b_out_imm, 64'h0);
    rst_n = 1'b1;
    idle(2);

    // addi x1,x0,5 and the one-cycle latency
    send(0, 32'h00500093, 32'h100, T_I, 64'd5, 4'b0000, 1, 1, 0, 0);
    chk("latency_valid", {63'h0, a_out_valid}, 64'h1);
    // beq x0,x0,-4
    send(0, 32'hFE000EE3, 32'h104, T_B, 64'hFFFF_FFFC, 4'b0001, 0, 1, 1, 0);
    idle(3);

    // back-pressure: add, sub, sw streamed against a stalled consumer
    a_out_ready = 1'b0;
    fork
      begin
        send(0, 32'h002081B3, 32'h110, T_R, 64'd0, 4'b0000, 1, 1, 1, 0);
        send(0, 32'h40208233, 32'h114, T_R, 64'd0, 4'b0001, 1, 1, 1, 0);
        send(0, 32'h0020A423, 32'h118, T_S, 64'd8, 4'b0000, 0, 1, 1, 0);
      end
      begin
        idle(3);
        chk("bp_in_ready", {63'h0, a_in_ready}, 64'h0);
        chk("bp_hold_pc", {32'h0, a_out_pc}, 64'h110);
        a_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_no_gap", {63'h0, a_out_valid}, 64'h1);
        end
      end
    join
    idle(3);

    // illegal forms, boundary shift encodings, and the counter
    send(0, 32'h0000007F, 32'h120, T_0, 64'd0, 4'b0000, 0, 0, 0, 1);
    send(0, 32'h02208033, 32'h124, T_0, 64'd0, 4'b0000, 0, 0, 0, 1);
    send(0, 32'h40109093, 32'h128, T_0, 64'd0, 4'b0000, 0, 0, 0, 1);
    send(0, 32'h4010D093, 32'h12C, T_I, 64'h401, 4'b1011, 1, 1, 0, 0);
    send(0, 32'h00500090, 32'h130, T_0, 64'd0, 4'b0000, 0, 0, 0, 1);
    idle(3);
    chk("illegal_count_a", {48'h0, a_illegal_count}, 64'd4);

    // flush with output and skid full and an input waiting
    a_out_ready = 1'b0;
    send(0, 32'h00500093, 32'h200, T_I, 64'd5, 4'b0000, 1, 1, 0, 0);
    send(0, 32'h002081B3, 32'h204, T_R, 64'd0, 4'b0000, 1, 1, 1, 0);
    a_in_valid = 1'b1; a_in_instr = 32'h0020A423; a_in_pc = 32'h208; a_flush = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_flush = 1'b0;
    qa.delete();
    chk("flush_out_valid", {63'h0, a_out_valid}, 64'h0);
    chk("flush_in_ready", {63'h0, a_in_ready}, 64'h1);
    // an input accepted in the flush cycle is dropped
    a_in_valid = 1'b1; a_in_instr = 32'h40208233; a_in_pc = 32'h20C; a_flush = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_flush = 1'b0;
    chk("flush_drop_valid", {63'h0, a_out_valid}, 64'h0);
    a_out_ready = 1'b1;
    idle(3);
    send(0, 32'hFE000EE3, 32'h300, T_B, 64'hFFFF_FFFC, 4'b0001, 0, 1, 1, 0);
    idle(3);
    chk("flush_count_kept", {48'h0, a_illegal_count}, 64'd4);

    // 64-bit instance: lui, mul (legal with M), jal -8
    send(1, 32'h800000B7, 32'h400, T_U, 64'hFFFF_FFFF_8000_0000, 4'b1110, 1, 0, 0, 0);
    send(1, 32'h02208033, 32'h404, T_R, 64'd0, 4'b1111, 0, 1, 1, 0);
    send(1, 32'hFF9FF0EF, 32'h408, T_J, 64'hFFFF_FFFF_FFFF_FFF8, 4'b0000, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      send(1, 32'h0000007F, 32'h410 + 32'(k * 4), T_0, 64'd0, 4'b0000, 0, 0, 0, 1);
    idle(3);
    chk("count_saturate_b", {62'h0, b_illegal_count}, 64'd3);

    // asynchronous reset while instructions are held
    b_out_ready = 1'b0;
    send(1, 32'h800000B7, 32'h500, T_U, 64'hFFFF_FFFF_8000_0000, 4'b1110, 1, 0, 0, 0);
    send(1, 32'h02208033, 32'h504, T_R, 64'd0, 4'b1111, 0, 1, 1, 0);
    chk("pre_reset_valid", {63'h0, b_out_valid}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'h0, b_out_valid}, 64'h0);
    chk("async_rst_ready", {63'h0, b_in_ready}, 64'h1);
    chk("async_rst_count", {62'h0, b_illegal_count}, 64'h0);
    chk("async_rst_imm", b_out_imm, 64'h0);
    qa.delete();
    qb.delete();
    #3 rst_n = 1'b1;
    b_out_ready = 1'b1;
    idle(3);

    chk("drained_a", 64'(qa.size()), 64'd0);
    chk("drained_b", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
